// File: rtl/prores_scan_pkg.sv
// Shared ProRes scan definitions: slice-buffer geometry, fill FSM states and the
// progressive scan map used by both the encoder read-out and the decoder gatherer.
package prores_scan_pkg;

  localparam int MAX_PIXEL_NUM = 64;
  localparam int MAX_BLOCK_NUM = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

  // Scan coefficient index -> raster position inside an 8x8 block.
  localparam logic [5:0] SCAN_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] scan_pos(input logic [5:0] coeff);
    return SCAN_TABLE[coeff];
  endfunction

endpackage

// File: rtl/ac_coeff_to_mem.sv
// Inverse-scan gatherer: writes interleaved-scan AC coefficients to their raster
// positions in a 2048-word slice buffer with a registered read port.
module ac_coeff_to_mem
  import prores_scan_pkg::*;
#(
  parameter int MAX_PIXEL_NUM = prores_scan_pkg::MAX_PIXEL_NUM,
  parameter int MAX_BLOCK_NUM = prores_scan_pkg::MAX_BLOCK_NUM,
  parameter int DATA_W        = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       block_num,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [5:0]        coeff_idx,
  output logic [4:0]        block_idx,
  input  logic [10:0]       rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = MAX_PIXEL_NUM * MAX_BLOCK_NUM;

  // Handshake: a beat transfers on a rising clock edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  fill_state_t       state;
  logic [4:0]        last_blk;
  logic              start_legal;
  logic              accept;
  logic [10:0]       wr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign start_legal = (block_num >= 32'd1) && (block_num <= 32'(MAX_BLOCK_NUM));
  assign in_ready    = (state == ST_FILL);
  assign busy        = (state == ST_FILL);
  assign done        = (state == ST_DONE);
  assign accept      = in_valid && in_ready;
  assign wr_addr     = {block_idx, scan_pos(coeff_idx)};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      coeff_idx <= 6'd1;
      block_idx <= 5'd0;
      last_blk  <= 5'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (start_legal) begin
              // block_num of 32 wraps to 31 in five bits, which is the intended last index.
              last_blk  <= block_num[4:0] - 5'd1;
              coeff_idx <= 6'd1;
              block_idx <= 5'd0;
              err       <= 1'b0;
              state     <= ST_FILL;
            end else begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_FILL: begin
          if (accept) begin
            if (block_idx != last_blk) begin
              block_idx <= block_idx + 5'd1;
            end else if (coeff_idx != 6'd63) begin
              block_idx <= 5'd0;
              coeff_idx <= coeff_idx + 6'd1;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Buffer storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
